// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC engine scheduler.
// Holds the scheduler state encoding, default operand width and channel-index width helper.
package cordic_pkg;

    typedef enum logic [1:0] {
        ARB,
        LAUNCH,
        WAIT,
        PUBLISH
    } sched_state_e;

    localparam int BIT_WIDTH_DEF = 24;

    // Channel index width, never less than one bit.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, with wrap.
// Ports: req_i request vector, ptr_i search start, gnt_o one-hot grant, idx_o grant index, any_o grant valid.
module rr_arbiter
    import cordic_pkg::*;
#(
    parameter int N = 4,
    localparam int W = ch_w(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j = 0;
        for (int k = 0; k < N; k++) begin
            // ptr_i is always below N, so one conditional subtract wraps
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W'(j);
            end
        end
    end

endmodule

// File: rtl/cordic_scheduler.sv
// Shares one iterative CORDIC phase engine between N_CH channels with round-robin grant,
// start sequencing, done timeout and tagged result publication.
// Ports: clk_i/rst_i (sync, active-high); req_valid_i/req_ready_o/req_sin_i/req_cos_i channel
// requests; eng_start_o/eng_sin_o/eng_cos_o/eng_phi_i/eng_done_i engine side; res_valid_o/
// res_ch_o/res_phi_o result strobe; err_timeout_o sticky timeout; busy_o not in ARB.
module cordic_scheduler
    import cordic_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int BIT_WIDTH      = BIT_WIDTH_DEF,
    parameter int START_LEN      = 2,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CH_BITS       = ch_w(N_CH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_CH-1:0]           req_valid_i,
    output logic [N_CH-1:0]           req_ready_o,
    input  logic [N_CH*BIT_WIDTH-1:0] req_sin_i,
    input  logic [N_CH*BIT_WIDTH-1:0] req_cos_i,
    output logic                      eng_start_o,
    output logic [BIT_WIDTH-1:0]      eng_sin_o,
    output logic [BIT_WIDTH-1:0]      eng_cos_o,
    input  logic [BIT_WIDTH-1:0]      eng_phi_i,
    input  logic                      eng_done_i,
    output logic                      res_valid_o,
    output logic [CH_BITS-1:0]        res_ch_o,
    output logic [BIT_WIDTH-1:0]      res_phi_o,
    output logic                      err_timeout_o,
    output logic                      busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + START_LEN + 1);
    localparam logic [CNT_W-1:0] START_END = CNT_W'(START_LEN);
    localparam logic [CNT_W-1:0] TMO_END   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    sched_state_e         state_q, state_d;
    logic [CH_BITS-1:0]   ptr_q, ptr_d;
    logic [CH_BITS-1:0]   gnt_q, gnt_d;
    logic [BIT_WIDTH-1:0] sin_q, sin_d;
    logic [BIT_WIDTH-1:0] cos_q, cos_d;
    logic [BIT_WIDTH-1:0] phi_q, phi_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [N_CH-1:0]      arb_gnt;
    logic [CH_BITS-1:0]   arb_idx;
    logic                 arb_any;

    rr_arbiter #(
        .N(N_CH)
    ) u_arb (
        .req_i(req_valid_i),
        .ptr_i(ptr_q),
        .gnt_o(arb_gnt),
        .idx_o(arb_idx),
        .any_o(arb_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        sin_d       = sin_q;
        cos_d       = cos_q;
        phi_d       = phi_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        req_ready_o = '0;
        unique case (state_q)
            ARB: begin
                if (arb_any) begin
                    req_ready_o = arb_gnt;
                    sin_d = req_sin_i[int'(arb_idx)*BIT_WIDTH +: BIT_WIDTH];
                    cos_d = req_cos_i[int'(arb_idx)*BIT_WIDTH +: BIT_WIDTH];
                    ptr_d = (arb_idx == CH_BITS'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
                    gnt_d   = arb_idx;
                    cnt_d   = CNT_ONE;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (cnt_q == START_END) begin
                    cnt_d   = CNT_ONE;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                // done takes priority over a coincident timeout
                if (eng_done_i) begin
                    phi_d   = eng_phi_i;
                    state_d = PUBLISH;
                end else if (cnt_q == TMO_END) begin
                    err_d   = 1'b1;
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PUBLISH: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sin_q   <= '0;
            cos_q   <= '0;
            phi_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sin_q   <= sin_d;
            cos_q   <= cos_d;
            phi_q   <= phi_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign eng_start_o   = (state_q == LAUNCH);
    assign eng_sin_o     = sin_q;
    assign eng_cos_o     = cos_q;
    assign res_valid_o   = (state_q == PUBLISH);
    assign res_ch_o      = res_valid_o ? gnt_q : '0;
    assign res_phi_o     = res_valid_o ? phi_q : '0;
    assign err_timeout_o = err_q;
    assign busy_o        = (state_q != ARB);

endmodule

// File: tb/tb_cordic_scheduler.sv
// Scoreboard bench for cordic_scheduler with a behavioural iterative engine.
// Expected results are queued on each grant and compared on each result strobe.
module tb_cordic_scheduler;

    localparam int N  = 4;
    localparam int BW = 24;

    typedef struct {
        int          ch;
        logic [23:0] phi;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*BW-1:0] req_sin;
    logic [N*BW-1:0] req_cos;
    logic          eng_start;
    logic [BW-1:0] eng_sin, eng_cos, eng_phi;
    logic          eng_done;
    logic          res_valid;
    logic [1:0]    res_ch;
    logic [BW-1:0] res_phi;
    logic          err_to;
    logic          busy;

    logic [BW-1:0] sin_drv [N];
    logic [BW-1:0] cos_drv [N];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   grants = 0;
    int   grant_cyc = 0;
    logic [N-1:0] last_gnt = '0;
    int   nres = 0;
    int   res_cyc = 0;
    int   last_res_ch = 0;
    int   starts = 0;
    exp_t q[$];

    // engine model
    logic eng_armed = 1'b0;
    int   since = 0;
    int   dly = 25;
    bit   dead = 1'b0;
    logic extra_done = 1'b0;

    always #5 clk = ~clk;

    for (genvar c = 0; c < N; c++) begin : g_pack
        assign req_sin[c*BW +: BW] = sin_drv[c];
        assign req_cos[c*BW +: BW] = cos_drv[c];
    end

    cordic_scheduler dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_sin_i(req_sin),
        .req_cos_i(req_cos),
        .eng_start_o(eng_start),
        .eng_sin_o(eng_sin),
        .eng_cos_o(eng_cos),
        .eng_phi_i(eng_phi),
        .eng_done_i(eng_done),
        .res_valid_o(res_valid),
        .res_ch_o(res_ch),
        .res_phi_o(res_phi),
        .err_timeout_o(err_to),
        .busy_o(busy)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (eng_start) begin
            eng_armed <= 1'b1;
            since     <= 0;
        end else if (eng_armed) begin
            since <= since + 1;
            if (since == dly) eng_armed <= 1'b0;
        end
    end

    assign eng_done = (eng_armed && !eng_start && since == dly && !dead)
                      || extra_done;
    assign eng_phi  = eng_sin + eng_cos;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (eng_start) starts++;
            if (|(req_ready & req_valid)) begin
                exp_t e;
                chk("ready_onehot", 64'($countones(req_ready)), 1);
                e.ch = 0;
                for (int c = 0; c < N; c++)
                    if (req_ready[c]) e.ch = c;
                e.phi = sin_drv[e.ch] + cos_drv[e.ch];
                q.push_back(e);
                grants++;
                grant_cyc = cyc;
                last_gnt  = req_ready;
            end
            if (res_valid) begin
                nres++;
                res_cyc     = cyc;
                last_res_ch = int'(res_ch);
                if (q.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_ch", 64'(res_ch), 64'(e.ch));
                    chk("res_phi", 64'(res_phi), 64'(e.phi));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int gc);
        int g0 = grants;
        int n = 0;
        while (grants == g0 && n < 300) begin
            tick();
            n++;
        end
        if (grants == g0) chk("grant_timeout", 0, 1);
        gc = grant_cyc;
    endtask

    task automatic wait_res(output int rc);
        int r0 = nres;
        int n = 0;
        while (nres == r0 && n < 300) begin
            tick();
            n++;
        end
        if (nres == r0) chk("res_timeout", 0, 1);
        rc = res_cyc;
    endtask

    task automatic set_ch(input int c, input logic [23:0] s,
                          input logic [23:0] k);
        sin_drv[c] = s;
        cos_drv[c] = k;
    endtask

    initial begin
        int gc, rc, prev, s0, r0, g0;
        for (int c = 0; c < N; c++) set_ch(c, '0, '0);

        // reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_outs", {req_ready, eng_start, eng_sin, eng_cos, res_valid,
                         res_ch, res_phi, err_to, busy}, 0);

        // all four channels continuously valid
        for (int c = 0; c < N; c++) set_ch(c, 24'(c), 24'h10);
        g0 = grants;
        req_valid = 4'hf;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_res(rc);
            chk("rr_order", 64'(last_res_ch), 64'(k % N));
            if (k > 0) chk("res_spacing", 64'(rc - prev), 30);
            prev = rc;
        end
        req_valid = '0;
        repeat (3) tick();
        chk("rr_grants", 64'(grants - g0), 5);
        chk("rr_idle", busy, 0);

        // single request on ch2
        set_ch(2, 24'h000100, 24'h000020);
        s0 = starts;
        req_valid = 4'b0100;
        wait_grant(gc);
        req_valid = '0;
        chk("single_ready", 64'(last_gnt), 4'b0100);
        chk("single_busy", busy, 1);
        wait_res(rc);
        chk("single_lat", 64'(rc - gc), 29);
        chk("single_start_len", 64'(starts - s0), 2);
        chk("res_one_cycle", res_valid, 0);

        // spurious done in ARB and LAUNCH
        set_ch(1, 24'h0abcde, 24'h011111);
        r0 = nres;
        extra_done = 1'b1;
        tick();
        extra_done = 1'b0;
        tick();
        req_valid = 4'b0010;
        wait_grant(gc);
        req_valid = '0;
        extra_done = 1'b1;
        tick();
        extra_done = 1'b0;
        wait_res(rc);
        chk("spur_lat", 64'(rc - gc), 29);
        chk("spur_count", 64'(nres - r0), 1);

        // done coincides with the final WAIT cycle
        dly = 63;
        set_ch(2, 24'h123456, 24'h0fedcb);
        req_valid = 4'b0100;
        wait_grant(gc);
        req_valid = '0;
        wait_res(rc);
        chk("coinc_lat", 64'(rc - gc), 67);
        tick();
        chk("coinc_err", err_to, 0);
        dly = 25;

        // engine never answers
        dead = 1'b1;
        r0 = nres;
        set_ch(3, 24'h000333, 24'h000444);
        req_valid = 4'b1000;
        wait_grant(gc);
        req_valid = '0;
        while (cyc < gc + 66) tick();
        chk("tmo_err_before", err_to, 0);
        chk("tmo_busy_before", busy, 1);
        tick();
        chk("tmo_err", err_to, 1);
        chk("tmo_busy_after", busy, 0);
        chk("tmo_no_res", 64'(nres - r0), 0);
        if (q.size() != 0) void'(q.pop_front());
        dead = 1'b0;
        set_ch(0, 24'h000007, 24'h000009);
        req_valid = 4'b0001;
        wait_grant(gc);
        req_valid = '0;
        wait_res(rc);
        chk("tmo_next_lat", 64'(rc - gc), 29);
        chk("err_sticky", err_to, 1);

        // reset ten cycles into WAIT
        set_ch(1, 24'h000111, 24'h000222);
        req_valid = 4'b0010;
        wait_grant(gc);
        req_valid = '0;
        while (cyc < gc + 12) tick();
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        chk("midrst_outs", {req_ready, eng_start, eng_sin, eng_cos, res_valid,
                            res_ch, res_phi, err_to, busy}, 0);
        set_ch(0, 24'h000aaa, 24'h000001);
        set_ch(3, 24'h000bbb, 24'h000002);
        req_valid = 4'b1011;
        wait_grant(gc);
        req_valid = '0;
        chk("midrst_ptr", 64'(last_gnt), 4'b0001);
        wait_res(rc);
        chk("midrst_lat", 64'(rc - gc), 29);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
